// File: rtl/cl_serial_pkg.sv
// Shared definitions for the Camera Link serial (SerTC/SerTFG) UART blocks.
package cl_serial_pkg;

  // Default width of the measured bit period and the bit-period down counter.
  localparam int BAUD_W_DEF = 16;

  // UART frame: 1 start bit, 8 data bits sent LSB first, 1 stop bit.
  localparam int         DATA_BITS = 8;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  // Receiver FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/cl_line_sync.sv
// Camera Link LVDS control-line front end: differential receive, optional
// P/N swap, metastability synchroniser and falling-edge detect.
// Usable for SerTC as well as the CC1-4 camera control inputs.
module cl_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic swap,
  input  logic pad_p,
  input  logic pad_n,
  output logic line,
  output logic fall
);

  logic                   ibuf_out;
  logic                   rx_raw;
  logic [SYNC_STAGES-1:0] sync;
  logic                   line_d;

  // Differential receiver model; a pair with no differential (both legs equal)
  // is forced to read as idle mark after the swap so it cannot fake a start bit.
  always_comb begin
    if (pad_p != pad_n) begin
      ibuf_out = pad_p;
    end else begin
      ibuf_out = ~swap;
    end
    rx_raw = ibuf_out ^ swap;
  end

  // Synchroniser chain and one-cycle delayed copy; both preset to idle mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '1;
      line_d <= 1'b1;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], rx_raw};
      line_d <= sync[SYNC_STAGES-1];
    end
  end

  assign line = sync[SYNC_STAGES-1];
  assign fall = line_d & ~line;

endmodule

// File: rtl/cl_serial_in.sv
// Camera Link SerTC receiver: 8N1 UART, LSB first, mid-bit sampling with the
// shared measured_baud bit period. Good bytes go to the command RX FIFO.
module cl_serial_in
  import cl_serial_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BAUD_W      = BAUD_W_DEF
) (
  input  logic              clk_fix,
  input  logic              rst_fix,
  input  logic [BAUD_W-1:0] measured_baud,
  input  logic              lvds_swap,
  input  logic              cl_sertc_p,
  input  logic              cl_sertc_n,
  input  logic              fifo_full,
  output logic              fifo_wen,
  output logic [7:0]        fifo_din,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overrun_err
);

  logic              rx_s;
  logic              fall;
  rx_state_e         state, state_nx;
  logic [BAUD_W-1:0] cnt, cnt_nx;
  logic [BAUD_W-1:0] baud_l, baud_nx;
  logic [2:0]        bit_idx, bit_nx;
  logic [7:0]        shreg, shreg_nx;
  logic              stop_sample;
  logic              wen_nx;
  logic              ferr_nx;
  logic              ovr_nx;
  logic [7:0]        din_nx;

  cl_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk   (clk_fix),
    .rst   (rst_fix),
    .swap  (lvds_swap),
    .pad_p (cl_sertc_p),
    .pad_n (cl_sertc_n),
    .line  (rx_s),
    .fall  (fall)
  );

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      baud_l  <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      baud_l  <= baud_nx;
      bit_idx <= bit_nx;
      shreg   <= shreg_nx;
    end
  end

  // Next state: half-period wait to mid start bit, then one full period per bit.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    baud_nx  = baud_l;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    case (state)
      ST_IDLE: begin
        if (fall && (measured_baud != '0)) begin
          state_nx = ST_START;
          cnt_nx   = measured_baud >> 1;
          baud_nx  = measured_baud;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt != '0) begin
          cnt_nx = cnt - BAUD_W'(1);
        end else if (!rx_s) begin
          state_nx = ST_DATA;
          bit_nx   = 3'd0;
          cnt_nx   = baud_l;
        end else begin
          state_nx = ST_IDLE;   // start bit gone by mid-bit: glitch
        end
      end
      ST_DATA: begin
        if (cnt != '0) begin
          cnt_nx = cnt - BAUD_W'(1);
        end else begin
          shreg_nx[bit_idx] = rx_s;
          cnt_nx            = baud_l;
          if (bit_idx == LAST_BIT) begin
            state_nx = ST_STOP;
          end else begin
            bit_nx = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - BAUD_W'(1);
        end else if (rx_s) begin
          state_nx = ST_IDLE;   // re-arm at mid stop so the next start edge is caught
        end else begin
          state_nx = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_BREAK;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Output decode at the stop-bit sample point; write and error cases are exclusive.
  always_comb begin
    stop_sample = (state == ST_STOP) && (cnt == '0);
    wen_nx      = stop_sample &  rx_s & ~fifo_full;
    ovr_nx      = stop_sample &  rx_s &  fifo_full;
    ferr_nx     = stop_sample & ~rx_s;
    if (wen_nx) begin
      din_nx = shreg;
    end else begin
      din_nx = fifo_din;
    end
  end

  // Registered outputs: strobes are single-cycle, fifo_din holds between writes.
  always_ff @(posedge clk_fix) begin
    if (rst_fix) begin
      fifo_wen    <= 1'b0;
      fifo_din    <= 8'h00;
      rx_busy     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      fifo_wen    <= wen_nx;
      fifo_din    <= din_nx;
      rx_busy     <= (state_nx != ST_IDLE);
      frame_err   <= ferr_nx;
      overrun_err <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_cl_serial_in.sv
// Directed testbench for cl_serial_in: drives UART frames onto the LVDS pair
// and checks received bytes, timing and error pulses against hand-computed values.
module tb_cl_serial_in;

  logic        clk_fix = 1'b0;
  logic        rst_fix;
  logic [15:0] measured_baud;
  logic        lvds_swap;
  logic        cl_sertc_p;
  logic        cl_sertc_n;
  logic        fifo_full;
  logic        fifo_wen;
  logic [7:0]  fifo_din;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int          cyc      = 0;
  int          wen_cyc  = 0;
  int          n_wen    = 0;
  int          n_ferr   = 0;
  int          n_ovr    = 0;
  int          n_busy   = 0;
  int          n_clash  = 0;
  logic [7:0]  rx_q[$];

  cl_serial_in #(
    .SYNC_STAGES (2),
    .BAUD_W      (16)
  ) dut (
    .clk_fix       (clk_fix),
    .rst_fix       (rst_fix),
    .measured_baud (measured_baud),
    .lvds_swap     (lvds_swap),
    .cl_sertc_p    (cl_sertc_p),
    .cl_sertc_n    (cl_sertc_n),
    .fifo_full     (fifo_full),
    .fifo_wen      (fifo_wen),
    .fifo_din      (fifo_din),
    .rx_busy       (rx_busy),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err)
  );

  always #5 clk_fix = ~clk_fix;

  // Free-running cycle count, used to time the write strobe.
  always @(posedge clk_fix) cyc <= cyc + 1;

  // Output monitor sampled on the falling edge, away from DUT updates.
  always @(negedge clk_fix) begin
    if (fifo_wen) begin
      rx_q.push_back(fifo_din);
      n_wen   <= n_wen + 1;
      wen_cyc <= cyc;
    end
    if (frame_err)   n_ferr <= n_ferr + 1;
    if (overrun_err) n_ovr  <= n_ovr + 1;
    if (rx_busy)     n_busy <= n_busy + 1;
    if ((32'(fifo_wen) + 32'(frame_err) + 32'(overrun_err)) > 32'd1) n_clash <= n_clash + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a logical line level onto the pair, honouring the board swap setting.
  task automatic drive_line(input logic v);
    cl_sertc_p = v ^ lvds_swap;
    cl_sertc_n = ~(v ^ lvds_swap);
  endtask

  task automatic set_swap(input logic s);
    lvds_swap  = s;
    cl_sertc_p = 1'b1 ^ s;
    cl_sertc_n = ~(1'b1 ^ s);
  endtask

  task automatic idle(input int n);
    drive_line(1'b1);
    repeat (n) @(negedge clk_fix);
  endtask

  // One 8N1 frame, bclk clocks per bit; called and returns on a falling edge.
  task automatic send_byte(input logic [7:0] d, input int bclk, input logic stop_v);
    drive_line(1'b0);
    repeat (bclk) @(negedge clk_fix);
    for (int i = 0; i < 8; i++) begin
      drive_line(d[i]);
      repeat (bclk) @(negedge clk_fix);
    end
    drive_line(stop_v);
    repeat (bclk) @(negedge clk_fix);
  endtask

  initial begin
    int         w0;
    int         t0;
    int         b0;
    logic [7:0] lb [4];
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55; lb[3] = 8'h3C;

    rst_fix       = 1'b1;
    measured_baud = 16'd10;
    fifo_full     = 1'b0;
    set_swap(1'b0);
    repeat (3) @(negedge clk_fix);
    check_val("rst_wen",   32'(fifo_wen),    32'd0);
    check_val("rst_din",   32'(fifo_din),    32'h00);
    check_val("rst_busy",  32'(rx_busy),     32'd0);
    check_val("rst_ferr",  32'(frame_err),   32'd0);
    check_val("rst_ovr",   32'(overrun_err), 32'd0);
    rst_fix = 1'b0;
    idle(10);

    // 0xA5 at 11 clk/bit. Start driven before edge 1, fall visible after edge 2,
    // stop sampled 105 clks after the fall, strobe one clk later: edge 108.
    w0 = n_wen;
    t0 = cyc;
    send_byte(8'hA5, 11, 1'b1);
    idle(20);
    check_val("a5_count",   32'(n_wen - w0),   32'd1);
    check_val("a5_latency", 32'(wen_cyc - t0), 32'd108);
    check_val("a5_data",    32'(rx_q[w0]),     32'hA5);
    check_val("a5_hold",    32'(fifo_din),     32'hA5);

    // 3-clk low glitch: busy from edge 3 through edge 8, idle again after edge 9.
    w0 = n_wen;
    drive_line(1'b0);
    repeat (3) @(negedge clk_fix);
    drive_line(1'b1);
    check_val("glitch_busy_on", 32'(rx_busy), 32'd1);
    repeat (5) @(negedge clk_fix);
    check_val("glitch_busy_e8", 32'(rx_busy), 32'd1);
    @(negedge clk_fix);
    check_val("glitch_busy_off", 32'(rx_busy), 32'd0);
    idle(150);
    check_val("glitch_no_wen", 32'(n_wen - w0), 32'd0);
    check_val("glitch_no_err", 32'(n_ferr + n_ovr), 32'd0);

    // Stop bit 0 then line held low: one frame error, no write, then recovery.
    w0 = n_wen;
    send_byte(8'h5A, 11, 1'b0);
    repeat (50) @(negedge clk_fix);
    check_val("brk_busy", 32'(rx_busy), 32'd1);
    idle(30);
    check_val("brk_ferr", 32'(n_ferr), 32'd1);
    check_val("brk_no_wen", 32'(n_wen - w0), 32'd0);
    send_byte(8'h96, 11, 1'b1);
    idle(20);
    check_val("brk_next_cnt",  32'(n_wen - w0), 32'd1);
    check_val("brk_next_data", 32'(rx_q[w0]),   32'h96);
    check_val("brk_ferr_once", 32'(n_ferr),     32'd1);

    // Back-to-back transmitter stream at baud 433 (434 clk/bit).
    measured_baud = 16'd433;
    w0 = n_wen;
    for (int i = 0; i < 4; i++) send_byte(lb[i], 434, 1'b1);
    idle(100);
    check_val("lb_count", 32'(n_wen - w0), 32'd4);
    for (int i = 0; i < 4; i++) check_val($sformatf("lb_data%0d", i), 32'(rx_q[w0 + i]), 32'(lb[i]));
    check_val("lb_no_err", 32'(n_ferr + n_ovr), 32'd1);

    // FIFO full during 0x81: overrun and drop; 0x7E with room is written.
    measured_baud = 16'd10;
    w0 = n_wen;
    fifo_full = 1'b1;
    send_byte(8'h81, 11, 1'b1);
    idle(20);
    fifo_full = 1'b0;
    check_val("ovr_pulse",  32'(n_ovr),       32'd1);
    check_val("ovr_no_wen", 32'(n_wen - w0),  32'd0);
    send_byte(8'h7E, 11, 1'b1);
    idle(20);
    check_val("ovr_next_cnt",  32'(n_wen - w0), 32'd1);
    check_val("ovr_next_data", 32'(rx_q[w0]),   32'h7E);

    // Swapped pair carrying 0xC3.
    set_swap(1'b1);
    idle(10);
    w0 = n_wen;
    send_byte(8'hC3, 11, 1'b1);
    idle(20);
    check_val("swap_cnt",  32'(n_wen - w0), 32'd1);
    check_val("swap_data", 32'(rx_q[w0]),   32'hC3);
    set_swap(1'b0);
    idle(10);

    // Reset in the middle of DATA: partial byte lost, no pulses, next frame fine.
    w0 = n_wen;
    drive_line(1'b0);
    repeat (11) @(negedge clk_fix);
    drive_line(1'b1);
    repeat (22) @(negedge clk_fix);
    drive_line(1'b0);
    repeat (11) @(negedge clk_fix);
    check_val("rstmid_busy_pre", 32'(rx_busy), 32'd1);
    drive_line(1'b1);
    rst_fix = 1'b1;
    repeat (2) @(negedge clk_fix);
    rst_fix = 1'b0;
    check_val("rstmid_busy", 32'(rx_busy), 32'd0);
    idle(200);
    check_val("rstmid_no_wen", 32'(n_wen - w0), 32'd0);
    check_val("rstmid_no_err", 32'(n_ferr + n_ovr), 32'd2);
    send_byte(8'h12, 11, 1'b1);
    idle(20);
    check_val("rstmid_next_cnt",  32'(n_wen - w0), 32'd1);
    check_val("rstmid_next_data", 32'(rx_q[w0]),   32'h12);

    // Receiver disabled: line activity must not start a frame.
    measured_baud = 16'd0;
    w0 = n_wen;
    b0 = n_busy;
    send_byte(8'h00, 11, 1'b1);
    send_byte(8'h55, 11, 1'b1);
    idle(50);
    check_val("dis_no_wen", 32'(n_wen - w0),  32'd0);
    check_val("dis_no_busy", 32'(n_busy - b0), 32'd0);

    check_val("pulse_exclusive", 32'(n_clash), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
